wb_scoreboard: RTL and testbench

- Register-hazard scoreboard fed by the writeback stage's output bus (writeback_if).
- Keeps one in-use bit per (warp, register). A bit is set when an instruction that writes a register issues, and cleared when the final writeback packet (eop) for that register retires.
- Gates the issue stage: an instruction may issue only when none of its source or destination registers are pending.
- Sits between the instruction buffer and the dispatch stage, alongside the writeback stage.

---
 rtl/wb_scoreboard_pkg.sv | 37 +++
 rtl/wb_scoreboard_watchdog.sv | 41 ++++
 rtl/wb_scoreboard.sv | 115 +++++++++++
 tb/tb_wb_scoreboard.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/wb_scoreboard_pkg.sv
// ============================================================================
// Module   : wb_scoreboard_pkg
// Purpose  : Shared widths and packet types for the register-hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_scoreboard_pkg;

    // Returns max(1, clog2(n)) so a single-warp build still has a 1-bit id
    function automatic int sb_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SB_NUM_WARPS = 4;
    localparam int SB_NUM_REGS  = 64;
    localparam int NW_BITS      = sb_bits(SB_NUM_WARPS);
    localparam int NR_BITS      = $clog2(SB_NUM_REGS);

    typedef struct packed {
        logic [NW_BITS-1:0] wid;
        logic               wb;
        logic [NR_BITS-1:0] rd;
        logic [NR_BITS-1:0] rs1;
        logic [NR_BITS-1:0] rs2;
        logic [NR_BITS-1:0] rs3;
    } sb_issue_t;

    typedef struct packed {
        logic [NW_BITS-1:0] wid;
        logic [NR_BITS-1:0] rd;
        logic               eop;
    } sb_release_t;

endpackage

`default_nettype wire

// File: rtl/wb_scoreboard_watchdog.sv
// ============================================================================
// Module   : wb_scoreboard_watchdog
// Purpose  : Consecutive-stall counter with a sticky deadlock flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_scoreboard_watchdog #(
    parameter int DEADLOCK_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    output logic deadlock
);

    localparam logic [31:0] C_LIMIT = 32'(DEADLOCK_CYCLES);

    logic [31:0] r_count;
    logic        r_deadlock;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_deadlock <= 1'b0;
        end else begin
            // Saturate so a very long stall cannot wrap and look healthy
            if (!stall)
                r_count <= '0;
            else if (r_count != '1)
                r_count <= r_count + 32'd1;
            if (stall && (r_count + 32'd1 >= C_LIMIT))
                r_deadlock <= 1'b1;
        end
    end

    assign deadlock = r_deadlock;

endmodule

`default_nettype wire

// File: rtl/wb_scoreboard.sv
// ============================================================================
// Module   : wb_scoreboard
// Purpose  : Per-(warp, register) in-use tracking that gates instruction issue.
//            Optional stall watchdog enabled by SCOREBOARD_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_scoreboard
    import wb_scoreboard_pkg::*;
#(
    parameter int NUM_WARPS       = SB_NUM_WARPS,
    parameter int NUM_REGS        = SB_NUM_REGS,
    parameter int DEADLOCK_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [NW_BITS-1:0]   wb_wid,
    input  logic [NR_BITS-1:0]   wb_rd,
    input  logic                 wb_eop,
    input  logic                 ibuf_valid,
    output logic                 ibuf_ready,
    input  logic [NW_BITS-1:0]   ibuf_wid,
    input  logic                 ibuf_wb,
    input  logic [NR_BITS-1:0]   ibuf_rd,
    input  logic [NR_BITS-1:0]   ibuf_rs1,
    input  logic [NR_BITS-1:0]   ibuf_rs2,
    input  logic [NR_BITS-1:0]   ibuf_rs3,
    output logic [NUM_WARPS-1:0] warp_idle,
    output logic                 release_err,
    output logic                 deadlock
);

    logic [NUM_REGS-1:0] r_inuse [NUM_WARPS];
    logic                r_release_err;

    sb_issue_t           w_iss;
    sb_release_t         w_rel;
    logic                w_release;
    logic                w_fire;
    logic                w_hazard;
    logic [NUM_REGS-1:0] w_row;

    assign w_iss     = '{wid: ibuf_wid, wb: ibuf_wb, rd: ibuf_rd,
                         rs1: ibuf_rs1, rs2: ibuf_rs2, rs3: ibuf_rs3};
    assign w_rel     = '{wid: wb_wid, rd: wb_rd, eop: wb_eop};
    assign w_release = wb_valid && w_rel.eop;
    assign wb_ready  = 1'b1;

    // A register retiring this cycle already reads as free to the candidate
    always_comb begin
        w_row = r_inuse[w_iss.wid];
        if (w_release && (w_rel.wid == w_iss.wid))
            w_row[w_rel.rd] = 1'b0;
        w_hazard = w_row[w_iss.rs1] | w_row[w_iss.rs2] | w_row[w_iss.rs3]
                 | (w_iss.wb & w_row[w_iss.rd]);
    end

    assign ibuf_ready = ibuf_valid && !w_hazard && !reset;
    assign w_fire     = ibuf_valid && ibuf_ready;

    // Set after clear so a same-cycle retire and re-reserve leaves the bit set
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++)
                r_inuse[w] <= '0;
        end else begin
            if (w_release && (w_rel.rd != '0))
                r_inuse[w_rel.wid][w_rel.rd] <= 1'b0;
            if (w_fire && w_iss.wb && (w_iss.rd != '0))
                r_inuse[w_iss.wid][w_iss.rd] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_release_err <= 1'b0;
        else if (w_release && (w_rel.rd != '0) && !r_inuse[w_rel.wid][w_rel.rd])
            r_release_err <= 1'b1;
    end

    assign release_err = r_release_err;

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_idle
        assign warp_idle[w] = ~|r_inuse[w];
    end

`ifdef SCOREBOARD_WATCHDOG_EN
    wb_scoreboard_watchdog #(
        .DEADLOCK_CYCLES (DEADLOCK_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .stall    (ibuf_valid && !ibuf_ready),
        .deadlock (deadlock)
    );

`ifndef SYNTHESIS
    logic r_deadlock_q;
    always_ff @(posedge clk) begin
        r_deadlock_q <= reset ? 1'b0 : deadlock;
        if (!reset && deadlock && !r_deadlock_q)
            $error("wb_scoreboard deadlock: warp %0d inuse=%h", ibuf_wid, r_inuse[ibuf_wid]);
    end
`endif
`else
    // Parameter kept referenced so the disabled build stays warning-free
    assign deadlock = 1'b0 & (DEADLOCK_CYCLES == 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_scoreboard.sv
// ============================================================================
// Module   : tb_wb_scoreboard
// Purpose  : Randomized scoreboard bench for wb_scoreboard against a set-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_scoreboard;

    localparam int NWARP = 4;
    localparam int NREG  = 64;
    localparam int DLC   = 16;

    logic       clk = 1'b0;
    logic       reset, wb_valid, wb_eop, ibuf_valid, ibuf_wb;
    logic       wb_ready, ibuf_ready, release_err, deadlock;
    logic [1:0] wb_wid, ibuf_wid;
    logic [5:0] wb_rd, ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
    logic [3:0] warp_idle;

    always #5 clk = ~clk;

    wb_scoreboard #(
        .NUM_WARPS(NWARP), .NUM_REGS(NREG), .DEADLOCK_CYCLES(DLC)
    ) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid),
        .wb_rd(wb_rd), .wb_eop(wb_eop),
        .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready), .ibuf_wid(ibuf_wid),
        .ibuf_wb(ibuf_wb), .ibuf_rd(ibuf_rd), .ibuf_rs1(ibuf_rs1),
        .ibuf_rs2(ibuf_rs2), .ibuf_rs3(ibuf_rs3),
        .warp_idle(warp_idle), .release_err(release_err), .deadlock(deadlock)
    );

    typedef struct {
        string   tag;
        bit      ready;
        bit [3:0] idle;
        bit      err;
        bit      dl;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: set of pending (warp, reg) pairs, sticky flags, stall run length
    bit m_pending[NWARP][NREG];
    bit m_err;
    bit m_dl;
    int m_stall;

    function automatic bit is_pending(int w, int r, bit rel, int rw, int rr);
        if (rel && w == rw && r == rr) return 1'b0;
        return m_pending[w][r];
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares each presented output against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.tag, ".ready"}, int'(ibuf_ready), int'(e.ready));
                check({e.tag, ".idle"}, int'(warp_idle), int'(e.idle));
                check({e.tag, ".err"}, int'(release_err), int'(e.err));
                check({e.tag, ".deadlock"}, int'(deadlock), int'(e.dl));
                check({e.tag, ".wb_ready"}, int'(wb_ready), 1);
            end
        end
    end

    task automatic step(string tag, bit rst,
                        bit wv, int ww, int wr, bit we,
                        bit iv, int iw, bit iwb, int ird, int r1, int r2, int r3);
        exp_t e;
        bit   rel, hz, fire;
        @(negedge clk);
        reset = rst; wb_valid = wv; wb_wid = 2'(ww); wb_rd = 6'(wr); wb_eop = we;
        ibuf_valid = iv; ibuf_wid = 2'(iw); ibuf_wb = iwb; ibuf_rd = 6'(ird);
        ibuf_rs1 = 6'(r1); ibuf_rs2 = 6'(r2); ibuf_rs3 = 6'(r3);
        #1;
        rel  = wv && we;
        hz   = is_pending(iw, r1, rel, ww, wr) || is_pending(iw, r2, rel, ww, wr)
            || is_pending(iw, r3, rel, ww, wr) || (iwb && is_pending(iw, ird, rel, ww, wr));
        fire = iv && !hz && !rst;
        e.tag = tag; e.ready = fire; e.err = m_err;
        `ifdef SCOREBOARD_WATCHDOG_EN e.dl = m_dl; `else e.dl = 1'b0; `endif
        for (int w = 0; w < NWARP; w++) begin
            e.idle[w] = 1'b1;
            for (int r = 0; r < NREG; r++)
                if (m_pending[w][r]) e.idle[w] = 1'b0;
        end
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            for (int w = 0; w < NWARP; w++)
                for (int r = 0; r < NREG; r++) m_pending[w][r] = 1'b0;
            m_err = 1'b0; m_dl = 1'b0; m_stall = 0;
        end else begin
            if (rel && wr != 0) begin
                if (!m_pending[ww][wr]) m_err = 1'b1;
                m_pending[ww][wr] = 1'b0;
            end
            if (fire && iwb && ird != 0) m_pending[iw][ird] = 1'b1;
            m_stall = (iv && !fire) ? m_stall + 1 : 0;
            if (m_stall >= DLC) m_dl = 1'b1;
        end
    endtask

    function automatic int pick_reg();
        return ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, NREG - 1))
                                           : int'($urandom_range(0, 7));
    endfunction

    initial begin
        int ww, wr;
        reset = 1'b1; wb_valid = 0; wb_eop = 0; ibuf_valid = 0; ibuf_wb = 0;
        wb_wid = 0; wb_rd = 0; ibuf_wid = 0; ibuf_rd = 0;
        ibuf_rs1 = 0; ibuf_rs2 = 0; ibuf_rs3 = 0;

        //        tag          rst wv ww wr we   iv iw wb rd r1 r2 r3
        step("reset0",        1, 0, 0, 0, 0,   1, 0, 1, 5, 0, 0, 0);
        step("reset1",        1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        step("issue_w0_r5",   0, 0, 0, 0, 0,   1, 0, 1, 5, 0, 0, 0);
        step("dep_stall",     0, 0, 0, 0, 0,   1, 0, 0, 0, 5, 0, 0);
        step("noneop_stall",  0, 1, 0, 5, 0,   1, 0, 0, 0, 5, 0, 0);
        step("eop_bypass",    0, 1, 0, 5, 1,   1, 0, 0, 0, 5, 0, 0);
        step("issue_w1_r7",   0, 0, 0, 0, 0,   1, 1, 1, 7, 0, 0, 0);
        step("rel_set_w1_r7", 0, 1, 1, 7, 1,   1, 1, 1, 7, 0, 0, 0);
        step("w2_r7_free",    0, 0, 0, 0, 0,   1, 2, 1, 7, 0, 0, 0);
        step("w1_r7_held",    0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 7, 0);
        step("rel_w1_r7",     0, 1, 1, 7, 1,   0, 0, 0, 0, 0, 0, 0);
        step("rel_w2_r7",     0, 1, 2, 7, 1,   0, 0, 0, 0, 0, 0, 0);
        step("issue_r0",      0, 0, 0, 0, 0,   1, 3, 1, 0, 0, 0, 0);
        step("rel_r0",        0, 1, 3, 0, 1,   0, 0, 0, 0, 0, 0, 0);
        step("spurious_rel",  0, 1, 3, 9, 1,   0, 0, 0, 0, 0, 0, 0);
        step("err_sticky",    0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        step("set_a",         0, 0, 0, 0, 0,   1, 0, 1, 3, 0, 0, 0);
        step("set_b",         0, 0, 0, 0, 0,   1, 1, 1, 4, 0, 0, 0);
        step("set_c",         0, 0, 0, 0, 0,   1, 2, 1, 6, 0, 0, 0);
        step("mid_reset",     1, 0, 0, 0, 0,   1, 3, 1, 8, 0, 0, 0);
        step("after_reset",   0, 0, 0, 0, 0,   1, 0, 0, 0, 3, 0, 0);

        for (int i = 0; i < 2000; i++) begin
            ww = int'($urandom_range(0, NWARP - 1));
            wr = pick_reg();
            // Bias releases toward reserved registers so hazards actually clear
            if ($urandom_range(0, 3) != 0)
                for (int r = 1; r < 8; r++)
                    if (m_pending[ww][r] && $urandom_range(0, 1) == 1) wr = r;
            step("rand", $urandom_range(0, 149) == 0,
                 $urandom_range(0, 1) == 1, ww, wr, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, int'($urandom_range(0, NWARP - 1)),
                 $urandom_range(0, 1) == 1, pick_reg(), pick_reg(), pick_reg(),
                 pick_reg());
        end

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
